// File: rtl/rs.sv
// Unified reservation station: two-wide dispatch, dual-CDB wakeup, issue to ALU0/ALU1/Mult/Branch.
// A mispredict on either branch port clears every entry and every issue port.
package rs_pkg;
    localparam int RS_SIZE = 16;
    localparam int RS_BITS = $clog2(RS_SIZE);

    localparam logic [4:0] ALU_ADDQ = 5'd1;

    typedef enum logic [1:0] {
        OP_INVALID = 2'd0,
        OP_ALU     = 2'd1,
        OP_MULT    = 2'd2,
        OP_BRANCH  = 2'd3
    } op_type_e;

    typedef struct packed {
        op_type_e    op_type;
        logic [4:0]  operation;
        logic        op1_ready;
        logic [63:0] op1_value;
        logic [5:0]  op1_prf_index;
        logic        op2_ready;
        logic [63:0] op2_value;
        logic [5:0]  op2_prf_index;
        logic [5:0]  dest_prf_index;
        logic [4:0]  rob_index;
        logic [63:0] next_pc;
        logic [63:0] branch_target_addr;
    } rs_entry_t;

    typedef struct packed {
        logic      dispatch;
        rs_entry_t data;
    } dispatch_rs_t;

    typedef struct packed {
        logic      busy;
        rs_entry_t data;
    } rs_data_t;

    typedef struct packed {
        logic      valid;
        rs_entry_t data;
    } issue_rs_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] fu_result;
        logic [5:0]  prn;
        logic [4:0]  rob_index;
        logic        mispredict;
        logic        thread_id;
    } cdb_t;
endpackage

module rs
    import rs_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  dispatch_rs_t             dispatch_inst0,
    input  dispatch_rs_t             dispatch_inst1,
    input  cdb_t                     CDB_0,
    input  cdb_t                     CDB_1,
    input  logic                     branch_mispredict_0,
    input  logic                     branch_mispredict_1,
    input  logic                     ALU0_ready,
    input  logic                     ALU1_ready,
    input  logic                     Mult_ready,
    input  logic                     Branch_ready,
    output issue_rs_t                issue_inst0,
    output issue_rs_t                issue_inst1,
    output issue_rs_t                issue_inst2,
    output issue_rs_t                issue_inst3,
    output logic                     full,
    output logic                     almost_full,
    output logic [RS_BITS:0]         count,
    output logic [RS_SIZE-1:0]       dispatch_free_list_debug,
    output logic [RS_SIZE-1:0]       awaken_ALU_list_debug,
    output logic [RS_SIZE-1:0]       awaken_Mult_list_debug,
    output logic [RS_SIZE-1:0]       awaken_Branch_list_debug,
    output rs_data_t [RS_SIZE-1:0]   RS_array_debug
);
    localparam logic [RS_BITS:0] ONE         = (RS_BITS+1)'(1);
    localparam logic [RS_BITS:0] FULL_COUNT  = (RS_BITS+1)'(RS_SIZE);
    localparam logic [RS_BITS:0] ALMOST_FULL = (RS_BITS+1)'(RS_SIZE - 1);

    rs_data_t  [RS_SIZE-1:0] entries_q, entries_d;
    issue_rs_t [3:0]         issue_q, issue_d;
    logic      [RS_BITS:0]   count_q, count_d;

    logic [RS_SIZE-1:0] free_list, alu_awake, mult_awake, branch_awake;
    logic [RS_BITS-1:0] f0, f1, a0, a1, m0, b0, alu1_sel, slot1;
    logic               f0_ok, f1_ok, a0_ok, a1_ok, m0_ok, b0_ok, alu1_ok;
    logic               acc0, acc1;
    logic [RS_BITS:0]   n_acc, n_iss;
    logic               unused_cdb_bits;

    assign unused_cdb_bits = ^{CDB_0.rob_index, CDB_0.mispredict, CDB_0.thread_id,
                               CDB_1.rob_index, CDB_1.mispredict, CDB_1.thread_id};

    // Operand capture from one CDB; also used for same-cycle forwarding at dispatch.
    function automatic rs_entry_t capture(input rs_entry_t e, input cdb_t c);
        rs_entry_t r;
        r = e;
        if (c.valid && !e.op1_ready && e.op1_prf_index == c.prn) begin
            r.op1_value = c.fu_result;
            r.op1_ready = 1'b1;
        end
        if (c.valid && !e.op2_ready && e.op2_prf_index == c.prn) begin
            r.op2_value = c.fu_result;
            r.op2_ready = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            free_list[i]    = !entries_q[i].busy;
            alu_awake[i]    = entries_q[i].busy && entries_q[i].data.op1_ready &&
                              entries_q[i].data.op2_ready && entries_q[i].data.op_type == OP_ALU;
            mult_awake[i]   = entries_q[i].busy && entries_q[i].data.op1_ready &&
                              entries_q[i].data.op2_ready && entries_q[i].data.op_type == OP_MULT;
            branch_awake[i] = entries_q[i].busy && entries_q[i].data.op1_ready &&
                              entries_q[i].data.op2_ready && entries_q[i].data.op_type == OP_BRANCH;
        end
    end

    // Priority encoders: two lowest free slots, two lowest awake ALU entries, lowest Mult/Branch.
    always_comb begin
        f0 = '0; f1 = '0; a0 = '0; a1 = '0; m0 = '0; b0 = '0;
        f0_ok = 1'b0; f1_ok = 1'b0; a0_ok = 1'b0; a1_ok = 1'b0; m0_ok = 1'b0; b0_ok = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (free_list[i]) begin
                if (!f0_ok) begin
                    f0 = RS_BITS'(i);
                    f0_ok = 1'b1;
                end else if (!f1_ok) begin
                    f1 = RS_BITS'(i);
                    f1_ok = 1'b1;
                end
            end
            if (alu_awake[i]) begin
                if (!a0_ok) begin
                    a0 = RS_BITS'(i);
                    a0_ok = 1'b1;
                end else if (!a1_ok) begin
                    a1 = RS_BITS'(i);
                    a1_ok = 1'b1;
                end
            end
            if (mult_awake[i] && !m0_ok) begin
                m0 = RS_BITS'(i);
                m0_ok = 1'b1;
            end
            if (branch_awake[i] && !b0_ok) begin
                b0 = RS_BITS'(i);
                b0_ok = 1'b1;
            end
        end
    end

    always_comb begin
        entries_d = entries_q;
        issue_d   = '0;
        n_iss     = '0;
        n_acc     = '0;
        alu1_sel  = ALU0_ready ? a1 : a0;
        alu1_ok   = ALU0_ready ? a1_ok : a0_ok;

        for (int i = 0; i < RS_SIZE; i++) begin
            if (entries_q[i].busy) begin
                entries_d[i].data = capture(capture(entries_q[i].data, CDB_0), CDB_1);
            end
        end

        // Issue reads registered state so a freshly woken entry waits one cycle.
        if (ALU0_ready && a0_ok) begin
            issue_d[0].valid  = 1'b1;
            issue_d[0].data   = entries_q[a0].data;
            entries_d[a0].busy = 1'b0;
            n_iss = n_iss + ONE;
        end
        if (ALU1_ready && alu1_ok) begin
            issue_d[1].valid  = 1'b1;
            issue_d[1].data   = entries_q[alu1_sel].data;
            entries_d[alu1_sel].busy = 1'b0;
            n_iss = n_iss + ONE;
        end
        if (Mult_ready && m0_ok) begin
            issue_d[2].valid  = 1'b1;
            issue_d[2].data   = entries_q[m0].data;
            entries_d[m0].busy = 1'b0;
            n_iss = n_iss + ONE;
        end
        if (Branch_ready && b0_ok) begin
            issue_d[3].valid  = 1'b1;
            issue_d[3].data   = entries_q[b0].data;
            entries_d[b0].busy = 1'b0;
            n_iss = n_iss + ONE;
        end

        acc0  = dispatch_inst0.dispatch && f0_ok;
        acc1  = dispatch_inst1.dispatch && (acc0 ? f1_ok : f0_ok);
        slot1 = acc0 ? f1 : f0;
        if (acc0) begin
            entries_d[f0].busy = 1'b1;
            entries_d[f0].data = capture(capture(dispatch_inst0.data, CDB_0), CDB_1);
            n_acc = n_acc + ONE;
        end
        if (acc1) begin
            entries_d[slot1].busy = 1'b1;
            entries_d[slot1].data = capture(capture(dispatch_inst1.data, CDB_0), CDB_1);
            n_acc = n_acc + ONE;
        end

        count_d = count_q + n_acc - n_iss;

        if (branch_mispredict_0 || branch_mispredict_1) begin
            entries_d = '0;
            issue_d   = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries_q <= '0;
            issue_q   <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            issue_q   <= issue_d;
            count_q   <= count_d;
        end
    end

    assign issue_inst0              = issue_q[0];
    assign issue_inst1              = issue_q[1];
    assign issue_inst2              = issue_q[2];
    assign issue_inst3              = issue_q[3];
    assign count                    = count_q;
    assign full                     = (count_q == FULL_COUNT);
    assign almost_full              = (count_q == ALMOST_FULL);
    assign dispatch_free_list_debug = free_list;
    assign awaken_ALU_list_debug    = alu_awake;
    assign awaken_Mult_list_debug   = mult_awake;
    assign awaken_Branch_list_debug = branch_awake;
    assign RS_array_debug           = entries_q;
endmodule

// File: tb/tb_rs.sv
// Self-checking bench for the reservation station: a cycle-vector table plus
// hand-written fill, wakeup, single-port issue and mispredict sequences.
module tb_rs;
   import rs_pkg::*;

   logic clock = 1'b0;
   logic reset;
   dispatch_rs_t dispatch_inst0, dispatch_inst1;
   cdb_t CDB_0, CDB_1;
   logic branch_mispredict_0, branch_mispredict_1;
   logic ALU0_ready, ALU1_ready, Mult_ready, Branch_ready;
   issue_rs_t issue_inst0, issue_inst1, issue_inst2, issue_inst3;
   logic full, almost_full;
   logic [RS_BITS:0] count;
   logic [RS_SIZE-1:0] freeList, awakeAlu, awakeMult, awakeBranch;
   rs_data_t [RS_SIZE-1:0] rsArray;

   int nCompared = 0;
   int nMismatched = 0;

   typedef struct {
      dispatch_rs_t d0;
      dispatch_rs_t d1;
      cdb_t c0;
      cdb_t c1;
      logic [1:0] mp;
      logic [3:0] rdy;
      int expCount;
      logic [3:0] expValid;
      logic [63:0] expA;
      logic [63:0] expB;
      logic [63:0] expD;
   } vec_t;

   vec_t vecs[17];

   rs dut (
      .clock(clock), .reset(reset),
      .dispatch_inst0(dispatch_inst0), .dispatch_inst1(dispatch_inst1),
      .CDB_0(CDB_0), .CDB_1(CDB_1),
      .branch_mispredict_0(branch_mispredict_0), .branch_mispredict_1(branch_mispredict_1),
      .ALU0_ready(ALU0_ready), .ALU1_ready(ALU1_ready),
      .Mult_ready(Mult_ready), .Branch_ready(Branch_ready),
      .issue_inst0(issue_inst0), .issue_inst1(issue_inst1),
      .issue_inst2(issue_inst2), .issue_inst3(issue_inst3),
      .full(full), .almost_full(almost_full), .count(count),
      .dispatch_free_list_debug(freeList),
      .awaken_ALU_list_debug(awakeAlu),
      .awaken_Mult_list_debug(awakeMult),
      .awaken_Branch_list_debug(awakeBranch),
      .RS_array_debug(rsArray)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Global time limit so a stuck run still ends with a FAIL line.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic dispatch_rs_t mkDisp(input logic en, input op_type_e t,
                                           input logic [5:0] p1, input logic r1, input logic [63:0] v1,
                                           input logic [5:0] p2, input logic r2, input logic [63:0] v2,
                                           input logic [4:0] rob);
      dispatch_rs_t d;
      d = '0;
      d.dispatch = en;
      d.data.op_type = t;
      d.data.operation = ALU_ADDQ;
      d.data.op1_prf_index = p1;
      d.data.op1_ready = r1;
      d.data.op1_value = v1;
      d.data.op2_prf_index = p2;
      d.data.op2_ready = r2;
      d.data.op2_value = v2;
      d.data.rob_index = rob;
      d.data.dest_prf_index = {1'b1, rob};
      return d;
   endfunction

   function automatic cdb_t mkCdb(input logic v, input logic [5:0] prn, input logic [63:0] val);
      cdb_t c;
      c = '0;
      c.valid = v;
      c.prn = prn;
      c.fu_result = val;
      return c;
   endfunction

   function automatic vec_t mkVec(input dispatch_rs_t d0, input dispatch_rs_t d1,
                                  input cdb_t c0, input cdb_t c1,
                                  input logic [1:0] mp, input logic [3:0] rdy,
                                  input int cnt, input logic [3:0] val,
                                  input logic [63:0] a, input logic [63:0] b, input logic [63:0] d);
      vec_t v;
      v.d0 = d0; v.d1 = d1; v.c0 = c0; v.c1 = c1;
      v.mp = mp; v.rdy = rdy;
      v.expCount = cnt; v.expValid = val;
      v.expA = a; v.expB = b; v.expD = d;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      dispatch_inst0 = '0;
      dispatch_inst1 = '0;
      CDB_0 = '0;
      CDB_1 = '0;
      branch_mispredict_0 = 1'b0;
      branch_mispredict_1 = 1'b0;
      ALU0_ready = 1'b0;
      ALU1_ready = 1'b0;
      Mult_ready = 1'b0;
      Branch_ready = 1'b0;
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      dispatch_inst0 = v.d0;
      dispatch_inst1 = v.d1;
      CDB_0 = v.c0;
      CDB_1 = v.c1;
      branch_mispredict_0 = v.mp[0];
      branch_mispredict_1 = v.mp[1];
      ALU0_ready = v.rdy[0];
      ALU1_ready = v.rdy[1];
      Mult_ready = v.rdy[2];
      Branch_ready = v.rdy[3];
   endtask

   task automatic doReset();
      clearInputs();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   task automatic checkLevel(input string tag, input int cnt, input logic f, input logic af);
      checkOutput({tag, " count"}, 64'(count), 64'(cnt));
      checkOutput({tag, " full"}, 64'(full), 64'(f));
      checkOutput({tag, " almost_full"}, 64'(almost_full), 64'(af));
   endtask

   task automatic fillPairs(input int n, input int robBase);
      for (int k = 0; k < n; k++) begin
         dispatch_inst0 = mkDisp(1'b1, OP_ALU, 6'd1, 1'b0, 64'd0, 6'd2, 1'b0, 64'd0, 5'(robBase + 2*k));
         dispatch_inst1 = mkDisp(1'b1, OP_ALU, 6'd1, 1'b0, 64'd0, 6'd2, 1'b0, 64'd0, 5'(robBase + 2*k + 1));
         stepCycle();
      end
      clearInputs();
   endtask

   task automatic fillOne(input int n);
      for (int k = 0; k < n; k++) begin
         dispatch_inst0 = mkDisp(1'b1, OP_ALU, 6'd1, 1'b0, 64'd0, 6'd2, 1'b0, 64'd0, 5'(k));
         stepCycle();
      end
      clearInputs();
   endtask

   task automatic mispredict(input logic m0, input logic m1);
      branch_mispredict_0 = m0;
      branch_mispredict_1 = m1;
      stepCycle();
      clearInputs();
   endtask

   initial begin
      dispatch_rs_t nd;
      cdb_t nc;
      nd = '0;
      nc = '0;

      // Cycle vectors: inputs held for one edge, outputs checked just after it.
      vecs[0]  = mkVec(mkDisp(1, OP_ALU, 0, 1, 5, 0, 1, 6, 1), mkDisp(1, OP_MULT, 0, 1, 7, 0, 1, 8, 2),
                       nc, nc, 2'b00, 4'b0000, 2, 4'b0000, 0, 0, 0);
      vecs[1]  = mkVec(nd, nd, nc, nc, 2'b00, 4'b0101, 0, 4'b0101, 5, 0, 0);
      vecs[2]  = mkVec(mkDisp(1, OP_ALU, 3, 0, 0, 0, 1, 9, 3), mkDisp(1, OP_BRANCH, 4, 0, 0, 0, 1, 1, 4),
                       mkCdb(1, 4, 44), nc, 2'b00, 4'b1111, 2, 4'b0000, 0, 0, 0);
      vecs[3]  = mkVec(nd, nd, nc, mkCdb(1, 3, 33), 2'b00, 4'b1111, 1, 4'b1000, 0, 0, 44);
      vecs[4]  = mkVec(nd, nd, nc, nc, 2'b00, 4'b1111, 0, 4'b0001, 33, 0, 0);
      vecs[5]  = mkVec(mkDisp(1, OP_ALU, 0, 1, 11, 0, 1, 1, 5), mkDisp(1, OP_ALU, 0, 1, 12, 0, 1, 1, 6),
                       nc, nc, 2'b00, 4'b0000, 2, 4'b0000, 0, 0, 0);
      vecs[6]  = mkVec(nd, nd, nc, nc, 2'b00, 4'b0010, 1, 4'b0010, 0, 11, 0);
      vecs[7]  = mkVec(mkDisp(1, OP_ALU, 0, 1, 13, 0, 1, 1, 7), nd,
                       nc, nc, 2'b00, 4'b0011, 1, 4'b0001, 12, 0, 0);
      vecs[8]  = mkVec(mkDisp(1, OP_ALU, 0, 1, 14, 0, 1, 1, 8), nd,
                       nc, nc, 2'b00, 4'b0011, 1, 4'b0001, 13, 0, 0);
      vecs[9]  = mkVec(mkDisp(1, OP_ALU, 0, 1, 15, 0, 1, 1, 9), mkDisp(1, OP_ALU, 0, 1, 16, 0, 1, 1, 10),
                       nc, nc, 2'b00, 4'b0011, 2, 4'b0001, 14, 0, 0);
      vecs[10] = mkVec(nd, nd, nc, nc, 2'b00, 4'b0011, 0, 4'b0011, 15, 16, 0);
      vecs[11] = mkVec(mkDisp(1, OP_ALU, 7, 0, 0, 0, 1, 1, 11), mkDisp(1, OP_ALU, 7, 0, 0, 0, 1, 1, 12),
                       nc, nc, 2'b00, 4'b0000, 2, 4'b0000, 0, 0, 0);
      vecs[12] = mkVec(mkDisp(1, OP_ALU, 0, 1, 20, 0, 1, 1, 13), nd,
                       mkCdb(1, 7, 70), nc, 2'b10, 4'b1111, 0, 4'b0000, 0, 0, 0);
      vecs[13] = mkVec(nd, nd, nc, nc, 2'b00, 4'b1111, 0, 4'b0000, 0, 0, 0);
      vecs[14] = mkVec(nd, nd, nc, nc, 2'b11, 4'b0000, 0, 4'b0000, 0, 0, 0);
      vecs[15] = mkVec(mkDisp(1, OP_INVALID, 0, 1, 1, 0, 1, 2, 14), nd,
                       nc, nc, 2'b00, 4'b1111, 1, 4'b0000, 0, 0, 0);
      vecs[16] = mkVec(nd, nd, nc, nc, 2'b00, 4'b1111, 1, 4'b0000, 0, 0, 0);

      // Reset state.
      doReset();
      checkLevel("reset", 0, 1'b0, 1'b0);
      checkOutput("reset free_list", 64'(freeList), 64'hFFFF);
      checkOutput("reset issue valids",
                  64'({issue_inst3.valid, issue_inst2.valid, issue_inst1.valid, issue_inst0.valid}), 0);

      // Table-driven cycle vectors.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i]);
         stepCycle();
         checkLevel($sformatf("v%0d", i), vecs[i].expCount, vecs[i].expCount == RS_SIZE,
                    vecs[i].expCount == RS_SIZE - 1);
         checkOutput($sformatf("v%0d issue valids", i),
                     64'({issue_inst3.valid, issue_inst2.valid, issue_inst1.valid, issue_inst0.valid}),
                     64'(vecs[i].expValid));
         if (vecs[i].expValid[0])
            checkOutput($sformatf("v%0d inst0 op1", i), issue_inst0.data.op1_value, vecs[i].expA);
         if (vecs[i].expValid[1])
            checkOutput($sformatf("v%0d inst1 op1", i), issue_inst1.data.op1_value, vecs[i].expB);
         if (vecs[i].expValid[3])
            checkOutput($sformatf("v%0d inst3 op1", i), issue_inst3.data.op1_value, vecs[i].expD);
      end
      clearInputs();

      // Fill one per cycle, overflow, then each mispredict flavour.
      doReset();
      fillOne(15);
      checkLevel("fill15", 15, 1'b0, 1'b1);
      fillOne(1);
      checkLevel("fill16", 16, 1'b1, 1'b0);
      checkOutput("fill16 free_list", 64'(freeList), 0);
      fillPairs(1, 20);
      checkLevel("overflow drop", 16, 1'b1, 1'b0);
      mispredict(1'b1, 1'b0);
      checkLevel("mp0 full", 0, 1'b0, 1'b0);
      checkOutput("mp0 free_list", 64'(freeList), 64'hFFFF);
      fillPairs(8, 0);
      mispredict(1'b1, 1'b1);
      checkLevel("mp both full", 0, 1'b0, 1'b0);
      fillPairs(8, 0);
      mispredict(1'b0, 1'b1);
      checkLevel("mp1 full", 0, 1'b0, 1'b0);

      // Two per cycle, and a pair arriving with a single free slot.
      doReset();
      fillPairs(7, 0);
      checkLevel("pairs14", 14, 1'b0, 1'b0);
      fillPairs(1, 14);
      checkLevel("pairs16", 16, 1'b1, 1'b0);
      mispredict(1'b1, 1'b0);
      fillOne(15);
      fillPairs(1, 30);
      checkLevel("one free pair", 16, 1'b1, 1'b0);
      checkOutput("one free entry15 rob", 64'(rsArray[15].data.rob_index), 30);

      // Sixteen waiting ADDQs woken by both CDBs in one cycle.
      doReset();
      fillPairs(8, 0);
      CDB_0 = mkCdb(1'b1, 6'd1, 64'd100);
      CDB_1 = mkCdb(1'b1, 6'd2, 64'd200);
      stepCycle();
      clearInputs();
      for (int e = 0; e < RS_SIZE; e++) begin
         checkOutput($sformatf("wake e%0d op1", e), rsArray[e].data.op1_value, 100);
         checkOutput($sformatf("wake e%0d op2", e), rsArray[e].data.op2_value, 200);
         checkOutput($sformatf("wake e%0d ready", e),
                     64'({rsArray[e].data.op1_ready, rsArray[e].data.op2_ready}), 64'(2'b11));
      end
      checkOutput("wake awake list", 64'(awakeAlu), 64'hFFFF);

      // Single woken entry issued on ALU0 only, then on ALU1 only.
      for (int p = 0; p < 2; p++) begin
         doReset();
         fillOne(1);
         CDB_0 = mkCdb(1'b1, 6'd1, 64'd100);
         CDB_1 = mkCdb(1'b1, 6'd2, 64'd200);
         ALU0_ready = (p == 0);
         ALU1_ready = (p == 1);
         stepCycle();
         checkOutput($sformatf("port%0d wake-cycle valids", p),
                     64'({issue_inst3.valid, issue_inst2.valid, issue_inst1.valid, issue_inst0.valid}), 0);
         CDB_0 = '0;
         CDB_1 = '0;
         stepCycle();
         clearInputs();
         checkOutput($sformatf("port%0d issue valids", p),
                     64'({issue_inst3.valid, issue_inst2.valid, issue_inst1.valid, issue_inst0.valid}),
                     (p == 0) ? 64'h1 : 64'h2);
         checkOutput($sformatf("port%0d op1", p),
                     (p == 0) ? issue_inst0.data.op1_value : issue_inst1.data.op1_value, 100);
         checkOutput($sformatf("port%0d op2", p),
                     (p == 0) ? issue_inst0.data.op2_value : issue_inst1.data.op2_value, 200);
         checkOutput($sformatf("port%0d count", p), 64'(count), 0);
      end

      // Mispredict with a single waiting entry.
      doReset();
      fillOne(1);
      mispredict(1'b0, 1'b1);
      checkLevel("mp single", 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
